uart_rx_oversampled: RTL and testbench

Parametrised successor to the existing fixed 8N1 UART receiver. It supports a configurable data width, parity mode and stop-bit count. Each bit is sampled with 16x oversampling and a majority vote, and the block flags parity, framing and overrun errors. Everything runs on the single system clock using an internal baud tick; received words leave through a valid/ready handshake toward the consuming logic (loopback/adder path, future FIFO).

---
 rtl/uart_rx_oversampled.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled UART receiver with configurable data/parity/stop
// framing, majority-vote bit sampling and a one-deep valid/ready holding register.
module uart_rx_oversampled #(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_next;
    logic                 rx_meta_p0, rx_sync_p1, rx_prev_p2;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           tick_cnt;
    logic [3:0]           bit_cnt;
    logic                 samp7, samp8;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err, frm_err;
    logic                 tick, at_sample, at_end, vote, fall;
    logic                 deliver, start_entry;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two-flop synchroniser, third flop only for falling-edge detection
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_meta_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
        end else begin
            rx_meta_p0 <= rx;
            rx_sync_p1 <= rx_meta_p0;
            rx_prev_p2 <= rx_sync_p1;
        end
    end

    assign tick      = (div_cnt == DIV_LAST);
    assign at_sample = tick && (tick_cnt == 4'd9);
    assign at_end    = tick && (tick_cnt == 4'd15);
    assign vote      = majority3(samp7, samp8, rx_sync_p1);
    assign fall      = rx_prev_p2 & ~rx_sync_p1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        deliver     = 1'b0;
        start_entry = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_next  = S_START;
                    start_entry = 1'b1;
                end
            end
            S_START: begin
                if (at_sample && vote) state_next = S_IDLE;
                else if (at_end)       state_next = S_DATA;
            end
            S_DATA: begin
                if (at_end && (bit_cnt == 4'(DATA_BITS - 1)))
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_end) state_next = S_STOP;
            end
            S_STOP: begin
                // Deliver mid-way through the last stop bit so a following start edge is not missed
                if (at_sample && (bit_cnt == 4'(STOP_BITS - 1))) begin
                    deliver    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            samp7    <= 1'b1;
            samp8    <= 1'b1;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else if (start_entry) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                if (tick_cnt == 4'd7) samp7 <= rx_sync_p1;
                if (tick_cnt == 4'd8) samp8 <= rx_sync_p1;
            end
            if (at_sample) begin
                case (state)
                    S_DATA:   shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    S_PARITY: par_err <= (^shreg) ^ vote ^ (PARITY == 2);
                    S_STOP:   frm_err <= frm_err | ~vote;
                    default:  ;
                endcase
            end
            if (at_end) begin
                case (state)
                    S_DATA:  bit_cnt <= (bit_cnt == 4'(DATA_BITS - 1)) ? 4'd0 : bit_cnt + 4'd1;
                    S_STOP:  bit_cnt <= bit_cnt + 4'd1;
                    default: bit_cnt <= 4'd0;
                endcase
            end
        end
    end

    // Holding register: a new frame is only dropped when the old word is neither free nor accepted
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data      <= '0;
            dataValid <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
        end else if (deliver) begin
            if (!dataValid || dataReady) begin
                data      <= shreg;
                parityErr <= par_err;
                frameErr  <= frm_err | ~vote;
                dataValid <= 1'b1;
                overrun   <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (dataValid && dataReady) begin
            dataValid <= 1'b0;
            overrun   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: three instances (8N1, 7E1, 8N2) at 32 clk per bit.
module tb_uart_rx_oversampled;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b0;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic valid_b, perr_b, ferr_b, ovr_b, busy_b;
    logic valid_c, perr_c, ferr_c, ovr_c, busy_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt_a = 0;
    int cap_cyc_a = 0;
    int t0, v0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    logic [9:0] w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_oversampled #(.CLOCK_RATE(3_200_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                          .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rstN(rstN), .rx(rx_a), .data(data_a), .dataValid(valid_a),
        .dataReady(ready_a), .parityErr(perr_a), .frameErr(ferr_a), .overrun(ovr_a), .busy(busy_a));

    uart_rx_oversampled #(.CLOCK_RATE(3_200_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                          .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rstN(rstN), .rx(rx_b), .data(data_b), .dataValid(valid_b),
        .dataReady(ready_b), .parityErr(perr_b), .frameErr(ferr_b), .overrun(ovr_b), .busy(busy_b));

    uart_rx_oversampled #(.CLOCK_RATE(3_200_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                          .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rstN(rstN), .rx(rx_c), .data(data_c), .dataValid(valid_c),
        .dataReady(ready_c), .parityErr(perr_c), .frameErr(ferr_c), .overrun(ovr_c), .busy(busy_c));

    // Record every accepted word as {frameErr, parityErr, data}
    always @(negedge clk) begin
        if (valid_a === 1'b1) vcnt_a <= vcnt_a + 1;
        if (valid_a === 1'b1 && ready_a === 1'b1) begin
            q_a.push_back({ferr_a, perr_a, data_a});
            cap_cyc_a <= cyc;
        end
        if (valid_b === 1'b1 && ready_b === 1'b1) q_b.push_back({ferr_b, perr_b, 1'b0, data_b});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic drive_frame(input int inst, input logic [19:0] bits, input int nb, input int spike_bit);
        for (int i = 0; i < nb; i++) begin
            set_rx(inst, bits[i]);
            if (i == spike_bit) begin
                step(18);
                set_rx(inst, ~bits[i]);
                step(2);
                set_rx(inst, bits[i]);
                step(12);
            end else begin
                step(32);
            end
        end
    endtask

    task automatic pop_a(output logic [9:0] x);
        if (q_a.size() > 0) x = q_a.pop_front();
        else x = '1;
    endtask

    task automatic pop_b(output logic [9:0] x);
        if (q_b.size() > 0) x = q_b.pop_front();
        else x = '1;
    endtask

    function automatic logic [19:0] f8n1(input logic [7:0] d);
        return {10'h0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [19:0] f7e1(input logic [6:0] d, input logic p);
        return {10'h0, 1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [19:0] f8n2(input logic [7:0] d, input logic s2);
        return {9'h0, s2, 1'b1, d, 1'b0};
    endfunction

    initial begin
        // Reset state
        step(3);
        chk("rst_data_a", data_a, 8'h00);
        chk("rst_valid_a", valid_a, 1'b0);
        chk("rst_ferr_a", ferr_a, 1'b0);
        chk("rst_ovr_a", ovr_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_perr_b", perr_b, 1'b0);
        rstN = 1'b1;
        step(5);

        // 8N1 0xA5 with dataReady held high
        t0 = cyc;
        v0 = vcnt_a;
        drive_frame(0, f8n1(8'hA5), 10, -1);
        step(40);
        chk("t1_count", q_a.size(), 1);
        pop_a(w);
        chk("t1_word", w, 10'h0A5);
        chk("t1_pulse_len", vcnt_a - v0, 1);
        chk("t1_latency", cap_cyc_a - t0, 311);
        chk("t1_valid_low", valid_a, 1'b0);

        // 7E1 0x55 with good then bad parity
        drive_frame(1, f7e1(7'h55, 1'b0), 10, -1);
        drive_frame(1, f7e1(7'h55, 1'b1), 10, -1);
        step(40);
        chk("t2_count", q_b.size(), 2);
        pop_b(w);
        chk("t2_good_par", w, 10'h055);
        pop_b(w);
        chk("t2_bad_par", w, 10'h155);

        // 8N2 0x3C with second stop bit low, then a 20-bit break
        drive_frame(2, f8n2(8'h3C, 1'b0), 11, -1);
        set_rx(2, 1'b1);
        step(40);
        chk("t3_valid", valid_c, 1'b1);
        chk("t3_data", data_c, 8'h3C);
        chk("t3_ferr", ferr_c, 1'b1);
        chk("t3_perr", perr_c, 1'b0);
        ready_c = 1'b1;
        step(1);
        ready_c = 1'b0;
        chk("t3_accept", valid_c, 1'b0);
        set_rx(2, 1'b0);
        step(640);
        chk("t3_brk_valid", valid_c, 1'b1);
        chk("t3_brk_data", data_c, 8'h00);
        chk("t3_brk_ferr", ferr_c, 1'b1);
        chk("t3_brk_ovr", ovr_c, 1'b0);
        chk("t3_brk_busy", busy_c, 1'b0);
        set_rx(2, 1'b1);
        step(64);
        chk("t3_rearm_ovr", ovr_c, 1'b0);
        chk("t3_rearm_busy", busy_c, 1'b0);

        // Overrun: three back-to-back frames with dataReady low
        ready_a = 1'b0;
        drive_frame(0, f8n1(8'h11), 10, -1);
        chk("t4_first_valid", valid_a, 1'b1);
        chk("t4_first_ovr", ovr_a, 1'b0);
        drive_frame(0, f8n1(8'h22), 10, -1);
        drive_frame(0, f8n1(8'h33), 10, -1);
        step(20);
        chk("t4_held_data", data_a, 8'h11);
        chk("t4_held_valid", valid_a, 1'b1);
        chk("t4_ovr", ovr_a, 1'b1);
        ready_a = 1'b1;
        step(1);
        ready_a = 1'b0;
        chk("t4_acc_valid", valid_a, 1'b0);
        chk("t4_acc_ovr", ovr_a, 1'b0);
        chk("t4_acc_count", q_a.size(), 1);
        pop_a(w);
        chk("t4_acc_word", w, 10'h011);
        step(100);
        chk("t4_lost", valid_a, 1'b0);
        ready_a = 1'b1;

        // Noise: quarter-bit glitch, then a one-tick spike in data bit 3
        v0 = vcnt_a;
        set_rx(0, 1'b0);
        step(8);
        set_rx(0, 1'b1);
        step(2);
        chk("t5_glitch_busy", busy_a, 1'b1);
        step(30);
        chk("t5_glitch_idle", busy_a, 1'b0);
        chk("t5_glitch_nout", vcnt_a - v0, 0);
        drive_frame(0, f8n1(8'hF0), 10, 4);
        step(40);
        chk("t5_spike_count", q_a.size(), 1);
        pop_a(w);
        chk("t5_spike_word", w, 10'h0F0);

        // Reset mid-way through data bit 4, then a clean 0x81
        drive_frame(0, f8n1(8'h81), 5, -1);
        set_rx(0, 1'b0);
        step(16);
        chk("t6_busy_pre", busy_a, 1'b1);
        rstN = 1'b0;
        #2;
        chk("t6_busy", busy_a, 1'b0);
        chk("t6_data_a", data_a, 8'h00);
        chk("t6_valid_c", valid_c, 1'b0);
        chk("t6_ferr_c", ferr_c, 1'b0);
        set_rx(0, 1'b1);
        step(3);
        rstN = 1'b1;
        step(5);
        drive_frame(0, f8n1(8'h81), 10, -1);
        step(40);
        chk("t6_count", q_a.size(), 1);
        pop_a(w);
        chk("t6_word", w, 10'h081);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
